// File: rtl/bus_apb_bridge.sv
// bus_apb_bridge: generic single-request bus (slave side) to APB4 master.
// One transfer in flight. IDLE -> SETUP -> ACCESS (waits on pready) -> RESP.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module bus_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bus_ena,
  input  logic [DATA_WIDTH/8-1:0] bus_wstb,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic                    bus_ready,
  output logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    bus_slverr,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   timeout;

  assign pprot = 3'b000;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Watchdog: cleared while entering ACCESS, counts ACCESS cycles without pready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tmo_cnt <= '0;
    else if (state == SETUP)           tmo_cnt <= '0;
    else if (state == ACCESS && !pready) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Expires on the cycle whose increment would reach the limit; pready wins.
  assign timeout = (state == ACCESS) && !pready &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; bus_ena only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_ena) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      bus_ready  <= 1'b0;
      bus_slverr <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      psel       <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable    <= (state_nxt == ACCESS);
      bus_ready  <= (state_nxt == RESP);
      bus_slverr <= 1'b0;
      // Request fields are taken once, at the IDLE edge, and then held.
      if (state == IDLE && bus_ena) begin
        paddr  <= bus_addr;
        pstrb  <= bus_wstb;
        pwdata <= bus_wdata;
        pwrite <= |bus_wstb;
      end
      if (state == ACCESS) begin
        if (pready) begin
          bus_rdata  <= pwrite ? '0 : prdata;
          bus_slverr <= pslverr;
        end else if (timeout) begin
          bus_rdata  <= '0;
          bus_slverr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_apb_bridge.sv
// Bench for bus_apb_bridge: directed transfers, scoreboard of expected responses
// popped when bus_ready pulses. Timeout scenario runs when APB_TIMEOUT_EN is defined.
module tb_bus_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_ena;
  logic [3:0]  bus_wstb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_slverr;
  logic [31:0] bus_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  typedef struct {logic [31:0] rdata; logic err;} rsp_t;
  rsp_t sb[$];

  int n_cmp = 0, n_err = 0, n_setup = 0, cyc = 0, setup_cyc = 0, prev_setup = 0;

  bus_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_ena(bus_ena), .bus_wstb(bus_wstb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_slverr(bus_slverr), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
    .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Response monitor: every bus_ready pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (psel && !penable) n_setup++;
    if (bus_ready) begin
      if (sb.size() == 0) chk("unexp_ready", bus_ready, 1'b0);
      else begin
        rsp_t r;
        r = sb.pop_front();
        chk("rsp_rdata", bus_rdata, r.rdata);
        chk("rsp_err", bus_slverr, r.err);
      end
    end
  end

  // One transfer; called #1 after a posedge, with the bridge in IDLE.
  task automatic do_xfer(input logic [31:0] addr, input logic [3:0] wstb,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdat, input logic err,
                         input bit keep, input bit scramble);
    rsp_t r;
    r.rdata = (wstb != 4'h0) ? 32'h0 : rdat;
    r.err   = err;
    sb.push_back(r);
    bus_ena = 1'b1; bus_addr = addr; bus_wstb = wstb; bus_wdata = wdata;
    pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1;
    prev_setup = setup_cyc; setup_cyc = cyc;
    chk("setup_psel", psel, 1'b1);
    chk("setup_pen", penable, 1'b0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wstb != 4'h0);
    chk("setup_pstrb", pstrb, wstb);
    chk("setup_pwdata", pwdata, wdata);
    if (scramble) begin bus_addr = ~addr; bus_wdata = ~wdata; bus_wstb = ~wstb; end
    @(posedge clk); #1;
    chk("acc_psel", psel, 1'b1);
    chk("acc_pen", penable, 1'b1);
    chk("acc_paddr", paddr, addr);
    chk("acc_pstrb", pstrb, wstb);
    chk("acc_pwdata", pwdata, wdata);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      chk("wait_pen", penable, 1'b1);
      chk("wait_rdy", bus_ready, 1'b0);
    end
    pready = 1'b1; prdata = rdat; pslverr = err;
    @(posedge clk); #1;
    chk("resp_rdy", bus_ready, 1'b1);
    chk("resp_psel", psel, 1'b0);
    chk("resp_pen", penable, 1'b0);
    pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
    if (!keep) bus_ena = 1'b0;
    @(posedge clk); #1;
    chk("post_rdy", bus_ready, 1'b0);
    chk("post_err", bus_slverr, 1'b0);
    chk("post_rdata_hold", bus_rdata, r.rdata);
    pslverr = 1'b0;
  endtask

  initial begin
    int exp_setups;
    rsp_t r;
    rst_n = 1'b0; bus_ena = 1'b0; bus_wstb = '0; bus_addr = '0; bus_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    exp_setups = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_pen", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_rdy", bus_ready, 1'b0);
    chk("rst_err", bus_slverr, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", pstrb, 4'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_pprot", pprot, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write, zero waits.
    do_xfer(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0, 0); exp_setups++;
    // Read, three wait states.
    do_xfer(32'h0000_0020, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 0); exp_setups++;
    // Read with completer error.
    do_xfer(32'h0000_0030, 4'h0, 32'h0, 0, 32'hCAFE_0001, 1'b1, 0, 0); exp_setups++;
    // Partial write; request fields disturbed after capture must not leak through.
    do_xfer(32'h0000_0044, 4'b0101, 32'hA5A5_5A5A, 1, 32'h0, 1'b0, 0, 1); exp_setups++;
    // Back-to-back: bus_ena held through RESP, new request right after bus_ready.
    do_xfer(32'h0000_0100, 4'h3, 32'h1111_2222, 0, 32'h0, 1'b0, 1, 0); exp_setups++;
    do_xfer(32'h0000_0104, 4'h0, 32'h0, 2, 32'h7777_8888, 1'b0, 0, 0); exp_setups++;
    chk("b2b_spacing", setup_cyc - prev_setup, 4);
    chk("b2b_setups", n_setup, exp_setups);

    // Reset asserted asynchronously mid-ACCESS: APB drops at once, no bus_ready.
    bus_ena = 1'b1; bus_addr = 32'h200; bus_wstb = 4'h0; pready = 1'b0;
    @(posedge clk); #1; bus_ena = 1'b0; exp_setups++;
    @(posedge clk); #3;
    chk("mid_acc_pen", penable, 1'b1);
    rst_n = 1'b0; #1;
    chk("arst_psel", psel, 1'b0);
    chk("arst_pen", penable, 1'b0);
    chk("arst_rdy", bus_ready, 1'b0);
    pready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; pready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle_psel", psel, 1'b0);

`ifdef APB_TIMEOUT_EN
    // Completer never answers: four ACCESS cycles then an error response.
    r.rdata = 32'h0; r.err = 1'b1; sb.push_back(r);
    bus_ena = 1'b1; bus_addr = 32'h300; bus_wstb = 4'h0; pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus_ena = 1'b0; exp_setups++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("tmo_pen", penable, 1'b1);
      chk("tmo_wait_rdy", bus_ready, 1'b0);
    end
    @(posedge clk); #1;
    chk("tmo_rdy", bus_ready, 1'b1);
    chk("tmo_psel", psel, 1'b0);
    @(posedge clk); #1;
    chk("tmo_post_rdy", bus_ready, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("total_setups", n_setup, exp_setups);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_apb_bridge.md
Name: bus_apb_bridge

Overview:
- Converts the team's generic single-request bus into an APB4 master transfer.
- Upstream side is the slave end of the generic bus: bus_ena, bus_wstb, bus_addr, bus_wdata, bus_ready, bus_rdata, bus_slverr.
- Downstream side drives one APB4 completer (PSEL/PENABLE/PREADY protocol).
- Sits between the bus master and the APB peripheral fabric; one transfer outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides; must be a multiple of 8.
- TIMEOUT_CYCLES, 256, number of ACCESS cycles allowed before abort. Only used with APB_TIMEOUT_EN.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- bus_ena  input  1  request valid; held high with fields stable until bus_ready.
- bus_wstb  input  DATA_WIDTH/8  byte write strobes; all-zero means read.
- bus_addr  input  ADDR_WIDTH  request address.
- bus_wdata  input  DATA_WIDTH  write data.
- bus_ready  output  1  one-cycle completion pulse.
- bus_rdata  output  DATA_WIDTH  read data; valid while bus_ready=1.
- bus_slverr  output  1  error flag; valid while bus_ready=1.
- paddr  output  ADDR_WIDTH  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pstrb  output  DATA_WIDTH/8  APB write strobes; zero on reads.
- pwdata  output  DATA_WIDTH  APB write data.
- pprot  output  3  tied to 3'b000.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB error.

Behaviour:
- Reset: rst_n low forces the following immediately, regardless of clk. Mid-transfer reset abandons the APB transfer; no bus_ready is issued.
  - state=IDLE
  - psel, penable, pwrite, bus_ready, bus_slverr = 0
  - paddr, pwdata, pstrb, bus_rdata = 0
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if bus_ena=1, capture bus_addr/bus_wstb/bus_wdata into paddr/pstrb/pwdata; set pwrite = |bus_wstb; go to SETUP.
  - SETUP: psel=1, penable=0; unconditionally go to ACCESS.
  - ACCESS: psel=1, penable=1; hold all APB fields stable.
    - If pready=1: capture prdata (reads only; writes leave bus_rdata=0) and pslverr; go to RESP.
    - Otherwise stay in ACCESS.
  - RESP: psel=0, penable=0, bus_ready=1 for exactly one cycle; bus_rdata/bus_slverr valid; go to IDLE.
- Latency:
  - bus_ena sampled high at edge N: SETUP is visible in cycle N+1, ACCESS in N+2.
  - With zero wait states, bus_ready is high in cycle N+3.
  - Each pready=0 cycle in ACCESS adds one cycle.
- Master obligations:
  - After seeing bus_ready, the master drops bus_ena or presents a new request.
  - bus_ena is ignored in RESP; it is sampled again only in IDLE. Minimum request-to-request spacing is therefore 4 cycles.
- Fields change while bus_ena=1 before capture: only the IDLE-edge values are used; later changes are ignored until the next IDLE.
- Captured data is not re-sampled after IDLE.
- bus_rdata holds its last value after RESP; bus_slverr returns to 0 outside RESP.
- pslverr is ignored unless pready=1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, go to RESP with bus_slverr=1 and bus_rdata=0.
  - psel/penable deassert in the RESP cycle.
  - pready=1 in the same cycle as expiry wins: normal completion.
- Without the macro: no counter is built, and ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero waits: bus_ena=1, wstb=4'hF, addr=32'h0000_0010, wdata=32'hDEAD_BEEF, pready=1 -> SETUP cycle 1, ACCESS cycle 2, pwrite=1, pstrb=4'hF; bus_ready=1 cycle 3, bus_slverr=0.
- Read with 3 wait states: wstb=0, addr=32'h20, pready low 3 ACCESS cycles then high with prdata=32'h1234_5678 -> pwrite=0, pstrb=0; bus_ready in cycle 6, bus_rdata=32'h1234_5678.
- Error: read with pready=1, pslverr=1 -> bus_ready=1 with bus_slverr=1 for one cycle, then bus_slverr=0.
- Partial write: wstb=4'b0101 -> pstrb=4'b0101, pwrite=1; fields stable through SETUP and ACCESS.
- Back-to-back: bus_ena held high, new request presented in the cycle after bus_ready -> second SETUP starts 4 cycles after the first; no duplicate transfer.
- Reset mid-ACCESS (and, with APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready stuck low):
  - Reset case: rst_n low asynchronously -> psel=penable=0 immediately, no bus_ready.
  - Timeout case: bus_ready with bus_slverr=1 after 4 ACCESS cycles.
